// File: rtl/uart_fifo_tx_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud
  localparam int DWIDTH_DEFAULT       = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Read side of the TX FIFO: the transmitter (master) pops, the FIFO (slave) supplies data.
interface uart_fifo_tx_if import uart_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEFAULT
);

  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_data;
  logic              fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_fifo_tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last cycle of each bit.
module uart_baud_counter import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = !clear && enable && (cnt_q == LAST);
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = bit_tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter that pops one byte per frame from a registered-output FIFO.
//
// state | meaning
// IDLE  | line high, waiting for tx_enable and a non-empty FIFO
// FETCH | one-cycle pop strobe to the FIFO
// LOAD  | FIFO read data now valid, captured into the shift register
// START | start bit (tx=0) for one bit period
// DATA  | DWIDTH data bits, LSB first
// STOP  | stop bit (tx=1); tx_done on its last cycle
module uart_fifo_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DWIDTH       = DWIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_enable,
  uart_fifo_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  localparam int            IW       = cnt_width(DWIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DWIDTH - 1);

  tx_state_t         state_q, state_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              baud_clear, baud_en, bit_tick;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .enable   (baud_en),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_idx_d       = bit_idx_q;
    fifo.fifo_rd_en = 1'b0;
    tx_done         = 1'b0;
    baud_clear      = 1'b1;
    baud_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_enable && !fifo.fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        fifo.fifo_rd_en = 1'b1;
        state_d         = LOAD;
      end
      LOAD: begin
        shift_d   = fifo.fifo_data;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: begin
        baud_clear = 1'b0;
        baud_en    = 1'b1;
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        baud_clear = 1'b0;
        baud_en    = 1'b1;
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      STOP: begin
        baud_clear = 1'b0;
        baud_en    = 1'b1;
        if (bit_tick) begin
          tx_done = 1'b1;
          state_d = (tx_enable && !fifo.fifo_empty) ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is decoded from the state being entered
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench: frame-table vectors, directed corner sequences and randomized traffic vs a cycle-count model.
module tb_uart_fifo_tx;

  localparam int CPB    = 4;
  localparam int DW     = 8;
  localparam int LAST_K = 2 + (DW + 2) * CPB - 1;  // cycles after the pop cycle to the last stop cycle

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_enable = 1'b0;
  logic tx, busy, tx_done;

  uart_fifo_tx_if #(.DWIDTH(DW)) fif ();

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .DWIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_enable (tx_enable),
    .fifo      (fif),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] env_q[$];  // contents of the FIFO the DUT reads
  logic [7:0] ref_q[$];  // model's view of the bytes still to be sent
  bit force_empty = 1'b0;
  bit prev_rd = 1'b0;

  // Reference model: frame in progress plus cycles elapsed since its pop cycle
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic [0:9] seq;
  } vec_t;

  vec_t tbl[6];

  task automatic check_vec(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= DW) return b[i-1];
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_out();
    logic t;
    t = 1'b1;
    if (m_active && m_k >= 2) t = frame_bit(m_byte, (m_k - 2) / CPB);
    return {t, m_active, (m_active && m_k == 0), (m_active && m_k == LAST_K)};
  endfunction

  task automatic model_edge();
    bit go;
    go = tx_enable && !fif.fifo_empty;
    if (!reset) begin
      m_active = 1'b0;
    end else if (!m_active || m_k == LAST_K) begin
      if (go) begin
        m_active = 1'b1;
        m_k      = 0;
        m_byte   = (ref_q.size() > 0) ? ref_q.pop_front() : 8'h00;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic upd_empty();
    fif.fifo_empty = force_empty || (env_q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    env_q.push_back(b);
    ref_q.push_back(b);
    upd_empty();
  endtask

  // One clock: advance the model across the edge, compare at the falling edge, service the FIFO
  task automatic cycle();
    model_edge();
    @(negedge clk);
    check_vec("outputs{tx,busy,rd_en,done}", 16'({tx, busy, fif.fifo_rd_en, tx_done}), 16'(model_out()));
    if (fif.fifo_rd_en) begin
      check_bit("proto_rd_when_empty", fif.fifo_empty, 1'b0);
      check_bit("proto_rd_multi_cycle", prev_rd, 1'b0);
      if (env_q.size() > 0) fif.fifo_data = env_q.pop_front();
    end
    prev_rd = fif.fifo_rd_en;
    upd_empty();
  endtask

  task automatic wait_rd(input string name, output int w);
    w = 0;
    while (!fif.fifo_rd_en && w < 20) begin
      cycle();
      w++;
    end
    check_bit(name, fif.fifo_rd_en, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, rd_c, dn_c, tx_low, busy_seen, drop, gap_bad, last_done;
    bit fin, started;

    tbl[0] = '{8'hA5, 10'b0101001011};
    tbl[1] = '{8'h00, 10'b0000000001};
    tbl[2] = '{8'hFF, 10'b0111111111};
    tbl[3] = '{8'h55, 10'b0101010101};
    tbl[4] = '{8'h01, 10'b0100000001};
    tbl[5] = '{8'h80, 10'b0000000011};

    // Reset held with enable high: nothing may start
    fif.fifo_data = '0;
    tx_enable = 1'b1;
    upd_empty();
    cycle();
    check_vec("reset_state", 16'({tx, busy, fif.fifo_rd_en, tx_done}), 16'(4'b1000));
    cycle();
    cycle();
    reset = 1'b1;

    // Empty FIFO with enable high for 100 cycles
    rd_c = 0; tx_low = 0; busy_seen = 0;
    repeat (100) begin
      cycle();
      if (fif.fifo_rd_en) rd_c++;
      if (!tx) tx_low++;
      if (busy) busy_seen++;
    end
    check_int("empty_no_pop", rd_c, 0);
    check_int("empty_tx_low", tx_low, 0);
    check_int("empty_busy", busy_seen, 0);

    // Single frames from the vector table
    for (int e = 0; e < 6; e++) begin
      logic [0:9] got;
      bit stable;
      int done_k, rd_extra;
      got = '0; stable = 1'b1; done_k = -1; rd_extra = 0;
      push(tbl[e].data);
      wait_rd($sformatf("tbl%0d_fetch", e), w);
      check_int($sformatf("tbl%0d_fetch_latency", e), w, 1);
      for (int k = 1; k <= LAST_K; k++) begin
        cycle();
        if (fif.fifo_rd_en) rd_extra++;
        if (tx_done) done_k = (done_k < 0) ? k : 99;
        if (k == 1 && tx !== 1'b1) stable = 1'b0;
        if (k >= 2) begin
          if ((k - 2) % CPB == 0) got[(k-2)/CPB] = tx;
          else if (tx !== got[(k-2)/CPB]) stable = 1'b0;
        end
      end
      check_vec($sformatf("tbl%0d_bits", e), 16'({stable, got}), 16'({1'b1, tbl[e].seq}));
      check_int($sformatf("tbl%0d_done_cycle", e), done_k, LAST_K);
      check_int($sformatf("tbl%0d_extra_pops", e), rd_extra, 0);
      cycle();
      check_bit($sformatf("tbl%0d_idle_after", e), busy, 1'b0);
    end

    // Three queued bytes back to back
    push(8'h00); push(8'hFF); push(8'h55);
    rd_c = 0; dn_c = 0; drop = 0; gap_bad = 0; last_done = -10; started = 1'b0; fin = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (fif.fifo_rd_en) begin
        rd_c++;
        if (rd_c > 1 && i != last_done + 1) gap_bad++;
        started = 1'b1;
      end
      if (tx_done) begin
        dn_c++;
        last_done = i;
      end
      if (started && !busy) begin
        if (dn_c < 3) drop++;
        else begin
          fin = 1'b1;
          break;
        end
      end
    end
    check_bit("b2b_finished", fin, 1'b1);
    check_int("b2b_pops", rd_c, 3);
    check_int("b2b_done_pulses", dn_c, 3);
    check_int("b2b_busy_drops", drop, 0);
    check_int("b2b_gap_errors", gap_bad, 0);

    // tx_enable dropped during the data bits of the first of two bytes
    push(8'h12); push(8'h34);
    wait_rd("endrop_fetch", w);
    rd_c = 0; dn_c = 0; fin = 1'b0;
    for (int i = 1; i < 200; i++) begin
      cycle();
      if (i == 12) tx_enable = 1'b0;
      if (fif.fifo_rd_en) rd_c++;
      if (tx_done) dn_c++;
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    repeat (5) cycle();
    check_bit("endrop_finished", fin, 1'b1);
    check_int("endrop_extra_pops", rd_c, 0);
    check_int("endrop_done_pulses", dn_c, 1);
    check_int("endrop_left_in_fifo", env_q.size(), 1);
    env_q.delete();
    ref_q.delete();
    upd_empty();
    tx_enable = 1'b1;

    // fifo_empty glitching high mid-frame must not disturb the frame
    push(8'h01); push(8'h80);
    wait_rd("glitch_fetch", w);
    rd_c = 0; dn_c = 0; fin = 1'b0;
    for (int i = 1; i < 300; i++) begin
      cycle();
      if (i == 10) begin force_empty = 1'b1; upd_empty(); end
      if (i == 25) begin force_empty = 1'b0; upd_empty(); end
      if (fif.fifo_rd_en) rd_c++;
      if (tx_done) dn_c++;
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    check_bit("glitch_finished", fin, 1'b1);
    check_int("glitch_second_pop", rd_c, 1);
    check_int("glitch_done_pulses", dn_c, 2);

    // Reset asserted during data bit 3 of 0x3C
    push(8'h3C);
    wait_rd("rst_fetch", w);
    for (int k = 1; k <= 19; k++) cycle();
    check_bit("rst_busy_before", busy, 1'b1);
    #1 reset = 1'b0;
    #1 check_vec("rst_async_outputs", 16'({tx, busy, fif.fifo_rd_en, tx_done}), 16'(4'b1000));
    repeat (3) cycle();
    reset = 1'b1;
    rd_c = 0; tx_low = 0; busy_seen = 0;
    repeat (30) begin
      cycle();
      if (fif.fifo_rd_en) rd_c++;
      if (!tx) tx_low++;
      if (busy) busy_seen++;
    end
    check_int("rst_no_resend", rd_c, 0);
    check_int("rst_tx_low", tx_low, 0);
    check_int("rst_busy", busy_seen, 0);

    // Randomized traffic with enable toggling, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4 && env_q.size() < 6) push(8'($urandom()));
      if ($urandom_range(0, 99) < 2) tx_enable = ~tx_enable;
      cycle();
    end
    tx_enable = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (env_q.size() == 0 && !busy) begin
        fin = 1'b1;
        break;
      end
    end
    check_bit("rand_drained", fin, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 The block SHALL use one clock and SHALL have an asynchronous, active-low reset.
REQ-002 Parameter CLKS_PER_BIT, default 434, SHALL give the number of clk cycles per serial bit (50 MHz / 115200).
REQ-003 Parameter DWIDTH, default 8, SHALL give the data bits per frame.
REQ-004 Port clk  in  1  SHALL be the system clock, rising-edge active.
REQ-005 Port reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port tx_enable  in  1  SHALL, when high, allow new frames to start.
REQ-007 Port fifo_empty  in  1  SHALL be the EMPTY flag of the TX FIFO.
REQ-008 Port fifo_data  in  DWIDTH  SHALL be the registered FIFO read data, valid one cycle after fifo_rd_en.
REQ-009 Port fifo_rd_en  out  1  SHALL be the FIFO pop strobe.
REQ-010 Port tx  out  1  SHALL be the registered serial line, idle high.
REQ-011 Port busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-012 Port tx_done  out  1  SHALL pulse for one cycle per completed frame.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-014 In IDLE, tx_enable=1 with fifo_empty=0 SHALL move the FSM to FETCH on the next edge; otherwise it stays in IDLE.
REQ-015 fifo_rd_en SHALL be high only while in FETCH; FETCH SHALL last exactly one cycle (one pop per frame, never popping when empty).
REQ-016 LOAD SHALL last one cycle, capture fifo_data into the shift register and go to START.
REQ-017 Frame format SHALL be 8N1: START holds tx=0, DATA sends DWIDTH bits LSB first, STOP holds tx=1, each for exactly CLKS_PER_BIT cycles.
REQ-018 A baud counter SHALL count 0..CLKS_PER_BIT-1, clear at each bit boundary, and be held at 0 in IDLE, FETCH and LOAD.
REQ-019 The bit index SHALL be $clog2(DWIDTH) bits wide and count 0..DWIDTH-1; DATA SHALL exit to STOP after index DWIDTH-1 completes.
REQ-020 tx SHALL be 0 from the first START cycle and 1 in IDLE, FETCH, LOAD and STOP.
REQ-021 tx_done SHALL be high on the last STOP cycle only.
REQ-022 At the end of STOP, tx_enable=1 with fifo_empty=0 SHALL go to FETCH; otherwise the FSM SHALL go to IDLE.
REQ-023 The idle gap between back-to-back frames SHALL be exactly 2 cycles (FETCH + LOAD).
REQ-024 Deasserting tx_enable mid-frame SHALL let the current frame finish, with no further fetch.
REQ-025 Changes on fifo_empty after FETCH SHALL NOT affect the frame in progress.
REQ-026 Total latency from the IDLE decision edge to the tx falling edge SHALL be 2 cycles; frame length SHALL be (DWIDTH+2)*CLKS_PER_BIT cycles.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, and baud counter, bit index and shift register to 0.
REQ-028 Reset mid-frame SHALL abort the frame; the popped byte is lost and no resend occurs.
REQ-029 After reset release, the first frame SHALL start no earlier than the first edge with reset=1.

Structure
REQ-030 Package uart_pkg SHALL hold the tx_state_t enum and the default CLKS_PER_BIT constant.
REQ-031 The baud counter SHALL be the sub-module uart_baud_counter, with inputs clear/enable and output bit_tick.
REQ-032 The implementation SHALL target 150-300 RTL lines and contain no combinational path from fifo_data to tx.

Verification
REQ-033 CLKS_PER_BIT=4, FIFO holds 0xA5, tx_enable=1 -> one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles each; tx_done at cycle 40 of the frame.
REQ-034 FIFO holds 0x00,0xFF,0x55 -> three frames with 2-cycle gaps and exactly 3 fifo_rd_en pulses; busy stays high throughout.
REQ-035 FIFO empty, tx_enable=1 for 100 cycles -> fifo_rd_en never asserted, tx=1, busy=0.
REQ-036 tx_enable dropped in the DATA phase of the first of two queued bytes -> first frame completes, second byte not popped, FSM returns to IDLE.
REQ-037 reset asserted at bit 3 of 0x3C -> tx=1 and busy=0 in the same cycle; after release with FIFO empty, no activity.
REQ-038 A protocol checker SHALL flag any fifo_rd_en with fifo_empty=1 and any fifo_rd_en lasting more than 1 cycle.
